// File: rtl/exec_ctrl_unit.sv
// Decode-control and execute stage of the RV32I pipeline: control decode, the
// decode/execute pipeline register, the ALU and the branch/jump redirect.
module exec_ctrl_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        bubble,
  input  logic [6:0]  d_opcode,
  input  logic [2:0]  d_funct3,
  input  logic [6:0]  d_funct7,
  input  logic [31:0] d_imm,
  input  logic [31:0] d_pc,
  input  logic [4:0]  d_rd,
  input  logic [31:0] e_rs1_data,
  input  logic [31:0] e_rs2_data,
  output logic        e_regwen,
  output logic        e_memrw,
  output logic [1:0]  e_wbsel,
  output logic [1:0]  e_access_size,
  output logic [4:0]  e_rd,
  output logic [31:0] e_pc,
  output logic [31:0] e_alu_out,
  output logic        e_pcsel
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       c_regwen;
  logic       c_asel;
  logic       c_bsel;
  logic       c_memrw;
  logic [1:0] c_wbsel;
  logic [1:0] c_access_size;
  logic       c_brun;

  always_comb begin
    c_regwen      = 1'b0;
    c_asel        = 1'b0;
    c_bsel        = 1'b0;
    c_memrw       = 1'b0;
    c_wbsel       = 2'd0;
    c_access_size = 2'd0;
    c_brun        = 1'b0;
    case (d_opcode)
      OP_R: begin
        c_regwen = 1'b1; c_wbsel = 2'd1; c_access_size = 2'd2;
      end
      OP_I, OP_LUI: begin
        c_regwen = 1'b1; c_bsel = 1'b1; c_wbsel = 2'd1; c_access_size = 2'd2;
      end
      OP_LOAD: begin
        c_regwen = 1'b1; c_bsel = 1'b1; c_wbsel = 2'd0;
        c_access_size = d_funct3[1:0];
      end
      OP_STORE: begin
        c_bsel = 1'b1; c_memrw = 1'b1; c_wbsel = 2'd1;
        c_access_size = d_funct3[1:0];
      end
      OP_BRANCH: begin
        c_asel = 1'b1; c_bsel = 1'b1; c_wbsel = 2'd1; c_access_size = 2'd2;
        c_brun = d_funct3[1];
      end
      OP_JAL: begin
        c_regwen = 1'b1; c_asel = 1'b1; c_bsel = 1'b1; c_wbsel = 2'd2;
        c_access_size = 2'd2;
      end
      OP_JALR: begin
        c_regwen = 1'b1; c_bsel = 1'b1; c_wbsel = 2'd2; c_access_size = 2'd2;
      end
      OP_AUIPC: begin
        c_regwen = 1'b1; c_asel = 1'b1; c_bsel = 1'b1; c_wbsel = 2'd1;
        c_access_size = 2'd2;
      end
      default: ;
    endcase
  end

  logic        r_asel;
  logic        r_bsel;
  logic        r_brun;
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic [31:0] r_imm;

  // An all-zero register is a NOP: opcode 0 decodes to no write, no store, no redirect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e_regwen      <= 1'b0;
      e_memrw       <= 1'b0;
      e_wbsel       <= 2'd0;
      e_access_size <= 2'd0;
      e_rd          <= 5'd0;
      e_pc          <= 32'd0;
      r_asel        <= 1'b0;
      r_bsel        <= 1'b0;
      r_brun        <= 1'b0;
      r_opcode      <= 7'd0;
      r_funct3      <= 3'd0;
      r_funct7      <= 7'd0;
      r_imm         <= 32'd0;
    end else if (bubble) begin
      e_regwen      <= 1'b0;
      e_memrw       <= 1'b0;
      e_wbsel       <= 2'd0;
      e_access_size <= 2'd0;
      e_rd          <= 5'd0;
      e_pc          <= 32'd0;
      r_asel        <= 1'b0;
      r_bsel        <= 1'b0;
      r_brun        <= 1'b0;
      r_opcode      <= 7'd0;
      r_funct3      <= 3'd0;
      r_funct7      <= 7'd0;
      r_imm         <= 32'd0;
    end else begin
      e_regwen      <= c_regwen;
      e_memrw       <= c_memrw;
      e_wbsel       <= c_wbsel;
      e_access_size <= c_access_size;
      e_rd          <= d_rd;
      e_pc          <= d_pc;
      r_asel        <= c_asel;
      r_bsel        <= c_bsel;
      r_brun        <= c_brun;
      r_opcode      <= d_opcode;
      r_funct3      <= d_funct3;
      r_funct7      <= d_funct7;
      r_imm         <= d_imm;
    end
  end

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_sum;
  logic [4:0]  shamt;
  logic        alt_op;
  logic        unused_funct7;

  assign alu_a         = r_asel ? e_pc  : e_rs1_data;
  assign alu_b         = r_bsel ? r_imm : e_rs2_data;
  assign alu_sum       = alu_a + alu_b;
  assign shamt         = alu_b[4:0];
  assign alt_op        = r_funct7[5];
  assign unused_funct7 = ^{r_funct7[6], r_funct7[4:0]};

  always_comb begin
    e_alu_out = 32'd0;
    case (r_opcode)
      OP_R, OP_I: begin
        case (r_funct3)
          3'b000: e_alu_out = (r_opcode == OP_R && alt_op) ? (alu_a - alu_b) : alu_sum;
          3'b001: e_alu_out = alu_a << shamt;
          3'b010: e_alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
          3'b011: e_alu_out = {31'd0, alu_a < alu_b};
          3'b100: e_alu_out = alu_a ^ alu_b;
          3'b101: e_alu_out = alt_op ? 32'($signed(alu_a) >>> shamt) : (alu_a >> shamt);
          3'b110: e_alu_out = alu_a | alu_b;
          default: e_alu_out = alu_a & alu_b;
        endcase
      end
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_AUIPC: e_alu_out = alu_sum;
      OP_JALR: e_alu_out = alu_sum & ~32'd1;
      OP_LUI:  e_alu_out = alu_b;
      default: e_alu_out = 32'd0;
    endcase
  end

  logic br_eq;
  logic br_lt;

  // Branch compare always uses the register operands, never the ALU inputs.
  assign br_eq = (e_rs1_data == e_rs2_data);
  assign br_lt = r_brun ? (e_rs1_data < e_rs2_data)
                        : ($signed(e_rs1_data) < $signed(e_rs2_data));

  always_comb begin
    e_pcsel = 1'b0;
    case (r_opcode)
      OP_JAL, OP_JALR: e_pcsel = 1'b1;
      OP_BRANCH: begin
        case (r_funct3)
          3'b000:         e_pcsel = br_eq;
          3'b001:         e_pcsel = ~br_eq;
          3'b100, 3'b110: e_pcsel = br_lt;
          3'b101, 3'b111: e_pcsel = ~br_lt;
          default:        e_pcsel = 1'b0;
        endcase
      end
      default: e_pcsel = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Self-checking bench for exec_ctrl_unit: vector table through a scoreboard queue,
// plus hand sequences for reset, bubble and operand forwarding.
module tb_exec_ctrl_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        bubble;
  logic [6:0]  d_opcode;
  logic [2:0]  d_funct3;
  logic [6:0]  d_funct7;
  logic [31:0] d_imm;
  logic [31:0] d_pc;
  logic [4:0]  d_rd;
  logic [31:0] e_rs1_data;
  logic [31:0] e_rs2_data;
  logic        e_regwen;
  logic        e_memrw;
  logic [1:0]  e_wbsel;
  logic [1:0]  e_access_size;
  logic [4:0]  e_rd;
  logic [31:0] e_pc;
  logic [31:0] e_alu_out;
  logic        e_pcsel;

  exec_ctrl_unit dut (
    .clock(clock), .reset(reset), .bubble(bubble),
    .d_opcode(d_opcode), .d_funct3(d_funct3), .d_funct7(d_funct7),
    .d_imm(d_imm), .d_pc(d_pc), .d_rd(d_rd),
    .e_rs1_data(e_rs1_data), .e_rs2_data(e_rs2_data),
    .e_regwen(e_regwen), .e_memrw(e_memrw), .e_wbsel(e_wbsel),
    .e_access_size(e_access_size), .e_rd(e_rd), .e_pc(e_pc),
    .e_alu_out(e_alu_out), .e_pcsel(e_pcsel)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        regwen;
    logic        memrw;
    logic [1:0]  wbsel;
    logic [1:0]  asz;
    logic [31:0] alu;
    logic        pcsel;
  } vec_t;

  typedef struct {
    logic        regwen;
    logic        memrw;
    logic [1:0]  wbsel;
    logic [1:0]  asz;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        pcsel;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm, input logic [31:0] pc,
                     input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic regwen, input logic memrw, input logic [1:0] wbsel,
                     input logic [1:0] asz, input logic [31:0] alu, input logic pcsel);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.imm = imm; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.regwen = regwen; v.memrw = memrw; v.wbsel = wbsel; v.asz = asz;
    v.alu = alu; v.pcsel = pcsel;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_regwen"}, {31'd0, e_regwen}, 32'd0);
    chk({tag, "_memrw"},  {31'd0, e_memrw}, 32'd0);
    chk({tag, "_wbsel"},  {30'd0, e_wbsel}, 32'd0);
    chk({tag, "_asz"},    {30'd0, e_access_size}, 32'd0);
    chk({tag, "_rd"},     {27'd0, e_rd}, 32'd0);
    chk({tag, "_pc"},     e_pc, 32'd0);
    chk({tag, "_alu"},    e_alu_out, 32'd0);
    chk({tag, "_pcsel"},  {31'd0, e_pcsel}, 32'd0);
  endtask

  initial begin
    // op, f3, f7, imm, pc, rs1, rs2 | regwen, memrw, wbsel, asz, alu, pcsel
    add(7'b0110011, 3'b000, 7'h00, 32'h0,        32'h100,      32'd5,        32'd7,  1,0,1,2, 32'd12,       0);
    add(7'b0110011, 3'b000, 7'h20, 32'h0,        32'h104,      32'd5,        32'd7,  1,0,1,2, 32'hFFFFFFFE, 0);
    add(7'b0110011, 3'b101, 7'h20, 32'h0,        32'h108,      32'h80000000, 32'd4,  1,0,1,2, 32'hF8000000, 0);
    add(7'b0010011, 3'b101, 7'h00, 32'd4,        32'h10C,      32'h80000000, 32'd0,  1,0,1,2, 32'h08000000, 0);
    add(7'b0110011, 3'b010, 7'h00, 32'h0,        32'h110,      32'hFFFFFFFF, 32'd1,  1,0,1,2, 32'd1,        0);
    add(7'b0110011, 3'b011, 7'h00, 32'h0,        32'h114,      32'hFFFFFFFF, 32'd1,  1,0,1,2, 32'd0,        0);
    add(7'b0010011, 3'b000, 7'h7F, 32'hFFFFFFFF, 32'h118,      32'd10,       32'd0,  1,0,1,2, 32'd9,        0);
    add(7'b0010011, 3'b001, 7'h00, 32'd31,       32'h11C,      32'd1,        32'd0,  1,0,1,2, 32'h80000000, 0);
    add(7'b0110011, 3'b100, 7'h00, 32'h0,        32'h120,      32'hF0F0,     32'hFF00, 1,0,1,2, 32'h0FF0,   0);
    add(7'b0110011, 3'b110, 7'h00, 32'h0,        32'h124,      32'hF0F0,     32'hFF00, 1,0,1,2, 32'hFFF0,   0);
    add(7'b0110011, 3'b111, 7'h00, 32'h0,        32'h128,      32'hF0F0,     32'hFF00, 1,0,1,2, 32'hF000,   0);
    add(7'b1100011, 3'b100, 7'h00, 32'd8,        32'h01000000, 32'hFFFFFFFF, 32'd1,  0,0,1,2, 32'h01000008, 1);
    add(7'b1100011, 3'b110, 7'h00, 32'd8,        32'h01000000, 32'hFFFFFFFF, 32'd1,  0,0,1,2, 32'h01000008, 0);
    add(7'b1100011, 3'b101, 7'h00, 32'd8,        32'h01000000, 32'hFFFFFFFF, 32'd1,  0,0,1,2, 32'h01000008, 0);
    add(7'b1100011, 3'b111, 7'h00, 32'd8,        32'h01000000, 32'hFFFFFFFF, 32'd1,  0,0,1,2, 32'h01000008, 1);
    add(7'b1100011, 3'b000, 7'h00, 32'hFFFFFFF0, 32'h200,      32'd3,        32'd3,  0,0,1,2, 32'h1F0,      1);
    add(7'b1100011, 3'b001, 7'h00, 32'hFFFFFFF0, 32'h200,      32'd3,        32'd3,  0,0,1,2, 32'h1F0,      0);
    add(7'b1100011, 3'b010, 7'h00, 32'd4,        32'h200,      32'd1,        32'd2,  0,0,1,2, 32'h204,      0);
    add(7'b1100111, 3'b000, 7'h00, 32'd4,        32'h300,      32'h01000103, 32'd0,  1,0,2,2, 32'h01000106, 1);
    add(7'b1101111, 3'b000, 7'h00, 32'h10,       32'h200,      32'd0,        32'd0,  1,0,2,2, 32'h210,      1);
    add(7'b0110111, 3'b000, 7'h00, 32'h12345000, 32'h400,      32'hDEAD,     32'd0,  1,0,1,2, 32'h12345000, 0);
    add(7'b0010111, 3'b000, 7'h00, 32'h2000,     32'h1000,     32'd0,        32'd0,  1,0,1,2, 32'h3000,     0);
    add(7'b0000011, 3'b001, 7'h00, 32'd4,        32'h500,      32'h100,      32'd0,  1,0,0,1, 32'h104,      0);
    add(7'b0100011, 3'b010, 7'h00, 32'hFFFFFFFC, 32'h504,      32'h200,      32'd9,  0,1,1,2, 32'h1FC,      0);
    add(7'b1111111, 3'b111, 7'h7F, 32'hFFFFFFFF, 32'h508,      32'd1,        32'd2,  0,0,0,0, 32'd0,        0);

    // Reset held low with arbitrary decode inputs.
    reset = 1'b0; bubble = 1'b0;
    d_opcode = 7'b0110011; d_funct3 = 3'b000; d_funct7 = 7'h00;
    d_imm = $urandom; d_pc = $urandom; d_rd = 5'd9;
    e_rs1_data = $urandom; e_rs2_data = $urandom;
    repeat (3) @(posedge clock);
    #1 check_all_zero("reset_hold");

    // Release mid-cycle: nothing loads until the next rising edge.
    #2 reset = 1'b1;
    e_rs1_data = 32'd1; e_rs2_data = 32'd2; d_pc = 32'h40; d_rd = 5'd1;
    #1 chk("release_no_load_regwen", {31'd0, e_regwen}, 32'd0);
    @(posedge clock); #1;
    chk("release_add_regwen", {31'd0, e_regwen}, 32'd1);
    chk("release_add_wbsel",  {30'd0, e_wbsel}, 32'd1);
    chk("release_add_alu",    e_alu_out, 32'd3);

    // Table vectors through the scoreboard.
    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clock);
      d_opcode = vecs[i].op; d_funct3 = vecs[i].f3; d_funct7 = vecs[i].f7;
      d_imm = vecs[i].imm; d_pc = vecs[i].pc; d_rd = 5'(i + 1);
      e_rs1_data = vecs[i].rs1; e_rs2_data = vecs[i].rs2;
      e.regwen = vecs[i].regwen; e.memrw = vecs[i].memrw; e.wbsel = vecs[i].wbsel;
      e.asz = vecs[i].asz; e.rd = 5'(i + 1); e.pc = vecs[i].pc;
      e.alu = vecs[i].alu; e.pcsel = vecs[i].pcsel;
      sb.push_back(e);
      @(posedge clock); #1;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL v%0d_scoreboard actual=empty required=entry", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_regwen", i), {31'd0, e_regwen}, {31'd0, e.regwen});
        chk($sformatf("v%0d_memrw", i),  {31'd0, e_memrw},  {31'd0, e.memrw});
        chk($sformatf("v%0d_wbsel", i),  {30'd0, e_wbsel},  {30'd0, e.wbsel});
        chk($sformatf("v%0d_asz", i),    {30'd0, e_access_size}, {30'd0, e.asz});
        chk($sformatf("v%0d_rd", i),     {27'd0, e_rd}, {27'd0, e.rd});
        chk($sformatf("v%0d_pc", i),     e_pc, e.pc);
        chk($sformatf("v%0d_alu", i),    e_alu_out, e.alu);
        chk($sformatf("v%0d_pcsel", i),  {31'd0, e_pcsel}, {31'd0, e.pcsel});
      end
    end

    // Forwarded operands change mid-cycle on a registered BLT / ADD.
    @(negedge clock);
    d_opcode = 7'b1100011; d_funct3 = 3'b100; d_funct7 = 7'h00;
    d_imm = 32'd8; d_pc = 32'h600; d_rd = 5'd0;
    e_rs1_data = 32'd5; e_rs2_data = 32'd1;
    @(posedge clock); #1;
    chk("fwd_blt_before", {31'd0, e_pcsel}, 32'd0);
    e_rs1_data = 32'hFFFFFFFE;
    #1 chk("fwd_blt_after", {31'd0, e_pcsel}, 32'd1);
    @(negedge clock);
    d_opcode = 7'b0110011; d_funct3 = 3'b000; d_funct7 = 7'h00;
    e_rs1_data = 32'd10; e_rs2_data = 32'd20;
    @(posedge clock); #1;
    chk("fwd_add_before", e_alu_out, 32'd30);
    e_rs2_data = 32'd100;
    #1 chk("fwd_add_after", e_alu_out, 32'd110);

    // Bubble over a taken BEQ.
    @(negedge clock);
    d_opcode = 7'b1100011; d_funct3 = 3'b000; d_imm = 32'd16; d_pc = 32'h700; d_rd = 5'd4;
    e_rs1_data = 32'd7; e_rs2_data = 32'd7; bubble = 1'b1;
    @(posedge clock); #1;
    check_all_zero("bubble");
    @(negedge clock) bubble = 1'b0;
    @(posedge clock); #1;
    chk("after_bubble_pcsel", {31'd0, e_pcsel}, 32'd1);
    chk("after_bubble_alu", e_alu_out, 32'h710);

    // Reset overrides bubble and acts asynchronously mid-cycle.
    @(negedge clock);
    d_opcode = 7'b1101111; d_imm = 32'h20; d_pc = 32'h800; d_rd = 5'd6;
    @(posedge clock); #1;
    chk("pre_async_pcsel", {31'd0, e_pcsel}, 32'd1);
    #2 reset = 1'b0; bubble = 1'b1;
    #1 check_all_zero("async_reset");
    @(posedge clock); #1;
    check_all_zero("reset_over_bubble");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
